bypass_regfile: RTL and testbench
=================================

BYPASS_REGFILE -- requirements
Module: bypass_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width of each register.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (power of two, >=2).
REQ-003 SHALL have parameter ZERO_REG, default DEPTH-1, index hardwired to zero; a value >=DEPTH disables the zero register.
REQ-004 SHALL have parameter BYPASS, default 1; 1 forwards same-cycle write data to reads, 0 returns stored contents only.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 SHALL have port wr_en  input  1  write enable.
REQ-008 SHALL have port wr_addr  input  AW=clog2(DEPTH)  write index.
REQ-009 SHALL have port wr_data  input  WIDTH  write data.
REQ-010 SHALL have ports rd_addr1, rd_addr2  input  AW  read indices.
REQ-011 SHALL have ports rd_data1, rd_data2  output  WIDTH  combinational read data.
REQ-012 SHALL have port claim_en  input  1  marks claim_addr pending (in-flight producer).
REQ-013 SHALL have port claim_addr  input  AW  register being claimed.
REQ-014 SHALL have ports busy1, busy2  output  1  pending flag for rd_addr1/rd_addr2.

Function
REQ-015 SHALL write wr_data into register wr_addr on the rising clk edge when wr_en=1; all other registers hold.
REQ-016 SHALL ignore writes to ZERO_REG; reads of ZERO_REG SHALL return 0 and busy SHALL read 0.
REQ-017 SHALL drive rd_dataN combinationally from register rd_addrN (zero read latency).
REQ-018 With BYPASS=1, SHALL return wr_data on rd_dataN when wr_en=1, wr_addr=rd_addrN, rd_addrN!=ZERO_REG.
REQ-019 With BYPASS=0, a same-address read in the write cycle SHALL return the old value; new value visible next cycle.
REQ-020 SHALL keep one pending bit per register; claim_en sets pending[claim_addr] on the rising edge.
REQ-021 A write (wr_en=1) SHALL clear pending[wr_addr] on the rising edge.
REQ-022 Simultaneous claim and write to the same address SHALL leave pending set (new producer wins).
REQ-023 busyN SHALL equal pending[rd_addrN], except 0 when BYPASS=1 and a write to rd_addrN occurs that cycle.
REQ-024 Claims of ZERO_REG SHALL be ignored.
REQ-025 Both read ports SHALL be independent; identical addresses SHALL return identical data and busy.

Reset
REQ-026 Asserting reset (0) SHALL immediately, without clk, clear every register to 0 and every pending bit to 0.
REQ-027 While reset=0, writes and claims SHALL be ignored; rd_dataN SHALL read 0 and busyN 0 (bypass included).
REQ-028 After reset deasserts, the first rising edge SHALL accept writes and claims normally.

Structure
REQ-029 A shared package regfile_pkg SHALL hold default WIDTH, DEPTH and the address-width computation.
REQ-030 One sub-module enabled_reg (WIDTH-bit register, enable, async active-low reset) SHALL be instantiated per register.
REQ-031 Pending bits, bypass compare and read multiplexers SHALL reside in bypass_regfile.

Verification
REQ-032 Reset mid-run: write 0xDEAD to r5, assert reset between edges -> rd_data1 (rd_addr1=5) reads 0 before next edge.
REQ-033 Write/read: wr r3=0x1234_5678, wr_en=0 next cycle with wr_data=0xFFFF -> r3 stays 0x1234_5678.
REQ-034 Bypass: wr_en=1, wr_addr=7, wr_data=0xAA, rd_addr1=7 same cycle -> rd_data1=0xAA (BYPASS=1), old value (BYPASS=0).
REQ-035 Zero register: write 0x55 to r31, claim r31 -> rd_data=0, busy=0 afterwards.
REQ-036 Scoreboard: claim r9 -> busy1=1 next cycle; write r9 -> busy1=0 in write cycle (BYPASS=1), then 0 after edge.
REQ-037 Collision: claim r4 and write r4 same edge -> pending[4]=1 after edge; data=written value.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address-width helper for the bypass register file
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_DEPTH = 32;

    // Index width for a file of 'depth' registers; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/enabled_reg.sv
// rtl/enabled_reg.sv - WIDTH-bit register with load enable and async active-low reset
//   clk   : rising-edge clock
//   reset : asynchronous active-low clear
//   en    : load d on the next rising edge
//   d, q  : data in / registered data out
module enabled_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bypass_regfile.sv
// rtl/bypass_regfile.sv - 2-read/1-write register file with write bypass and pending scoreboard
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : write port (also retires the pending bit of wr_addr)
//   rd_addr1/2, rd_data1/2: combinational read ports
//   claim_en/claim_addr   : marks a register as having an in-flight producer
//   busy1/busy2           : pending flag of the register addressed by each read port
module bypass_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ZERO_REG = DEPTH - 1,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             claim_en,
    input  logic [AW-1:0]    claim_addr,
    output logic             busy1,
    output logic             busy2
);

    // An out-of-range ZERO_REG means every index is an ordinary register.
    localparam bit HAS_ZERO = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);

    function automatic logic is_zero(input logic [AW-1:0] a);
        return HAS_ZERO && (int'(a) == ZERO_REG);
    endfunction

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic             byp1;
    logic             byp2;

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (HAS_ZERO && (i == ZERO_REG)) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_live
            logic en;
            assign en = wr_en && (wr_addr == AW'(i));
            enabled_reg #(.WIDTH(WIDTH)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .d     (wr_data),
                .q     (regs[i])
            );
        end
    end

    // Claim is applied after the write-clear so a same-edge claim and write
    // to one register leaves it pending: the new producer wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[wr_addr] = 1'b0;
        end
        if (claim_en && !is_zero(claim_addr)) begin
            pending_d[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Forwarding is gated by reset so reads stay zero while reset is held.
    always_comb begin
        byp1     = (BYPASS != 0) && reset && wr_en && (wr_addr == rd_addr1) && !is_zero(rd_addr1);
        byp2     = (BYPASS != 0) && reset && wr_en && (wr_addr == rd_addr2) && !is_zero(rd_addr2);
        rd_data1 = byp1 ? wr_data : regs[rd_addr1];
        rd_data2 = byp2 ? wr_data : regs[rd_addr2];
        busy1    = pending_q[rd_addr1] && !byp1;
        busy2    = pending_q[rd_addr2] && !byp2;
    end

endmodule

// File: tb/tb_bypass_regfile.sv
// tb/tb_bypass_regfile.sv - randomized self-checking bench for bypass_regfile (BYPASS=1 and BYPASS=0)
module tb_bypass_regfile;

    localparam int ZR = 31;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        claim_en;
    logic [4:0]  claim_addr;

    logic [63:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        by1_a, by2_a, by1_b, by2_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mem  [32];
    bit          pend [32];

    always #5 clk = ~clk;

    bypass_regfile #(.BYPASS(1)) u_dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_a), .rd_data2(rd2_a),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy1(by1_a), .busy2(by2_a)
    );

    bypass_regfile #(.BYPASS(0)) u_dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_b), .rd_data2(rd2_b),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy1(by1_b), .busy2(by2_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_rd(input bit bp, input logic [4:0] ra);
        if (!reset) return 64'd0;
        if (ra == ZR) return 64'd0;
        if (bp && wr_en && wr_addr == ra) return wr_data;
        return mem[ra];
    endfunction

    function automatic logic [63:0] exp_busy(input bit bp, input logic [4:0] ra);
        if (!reset || ra == ZR) return 64'd0;
        if (bp && wr_en && wr_addr == ra) return 64'd0;
        return {63'd0, pend[ra]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem[i]  = 64'd0;
            pend[i] = 1'b0;
        end
    endtask

    task automatic drive(input bit rst, input bit we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2,
                         input bit ce, input logic [4:0] ca);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr1 = ra1; rd_addr2 = ra2; claim_en = ce; claim_addr = ca;
        if (!rst) model_clear();
        #1;
        check("rd1_byp",   rd1_a, exp_rd(1'b1, ra1));
        check("rd2_byp",   rd2_a, exp_rd(1'b1, ra2));
        check("busy1_byp", {63'd0, by1_a}, exp_busy(1'b1, ra1));
        check("busy2_byp", {63'd0, by2_a}, exp_busy(1'b1, ra2));
        check("rd1_nob",   rd1_b, exp_rd(1'b0, ra1));
        check("rd2_nob",   rd2_b, exp_rd(1'b0, ra2));
        check("busy1_nob", {63'd0, by1_b}, exp_busy(1'b0, ra1));
        check("busy2_nob", {63'd0, by2_b}, exp_busy(1'b0, ra2));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            if (wr_en) begin
                if (wr_addr != ZR) mem[wr_addr] = wr_data;
                pend[wr_addr] = 1'b0;
            end
            if (claim_en && claim_addr != ZR) pend[claim_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) return 5'(ZR);
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        model_clear();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        check("reset_rd1", rd1_a, 64'd0);
        tick();
        drive(0, 1, 2, 64'h77, 2, 3, 1, 2);
        tick();
        @(negedge clk);

        // write then hold
        drive(1, 1, 3, 64'h1234_5678, 0, 0, 0, 0); tick();
        drive(1, 0, 3, 64'hFFFF, 3, 3, 0, 0);      tick();
        drive(1, 0, 0, 0, 3, 0, 0, 0);
        check("r3_hold", rd1_a, 64'h1234_5678);

        // same-cycle bypass versus stored value
        drive(1, 1, 7, 64'h11, 0, 0, 0, 0); tick();
        drive(1, 1, 7, 64'hAA, 7, 0, 0, 0);
        check("byp_new", rd1_a, 64'hAA);
        check("nob_old", rd1_b, 64'h11);
        tick();
        drive(1, 0, 0, 0, 7, 0, 0, 0);
        check("nob_after", rd1_b, 64'hAA);

        // zero register
        drive(1, 1, 31, 64'h55, 31, 31, 1, 31);
        check("zero_byp", rd1_a, 64'd0);
        tick();
        drive(1, 0, 0, 0, 31, 31, 0, 0);
        check("zero_rd", rd1_a, 64'd0);
        check("zero_busy", {63'd0, by2_a}, 64'd0);

        // scoreboard
        drive(1, 0, 0, 0, 0, 0, 1, 9); tick();
        drive(1, 0, 0, 0, 9, 9, 0, 0);
        check("claim_busy", {63'd0, by1_a}, 64'd1);
        drive(1, 1, 9, 64'h99, 9, 9, 0, 0);
        check("wr_busy_byp", {63'd0, by1_a}, 64'd0);
        check("wr_busy_nob", {63'd0, by1_b}, 64'd1);
        tick();
        drive(1, 0, 0, 0, 9, 9, 0, 0);
        check("retired", {63'd0, by1_b}, 64'd0);

        // claim and write collide
        drive(1, 1, 4, 64'h4444, 0, 0, 1, 4); tick();
        drive(1, 0, 0, 0, 4, 4, 0, 0);
        check("coll_busy", {63'd0, by1_a}, 64'd1);
        check("coll_data", rd2_b, 64'h4444);

        // reset between edges
        drive(1, 1, 5, 64'hDEAD, 0, 0, 1, 5); tick();
        drive(1, 0, 0, 0, 5, 5, 0, 0);
        check("dead_pre", rd1_a, 64'hDEAD);
        #2;
        drive(0, 1, 5, 64'hBEEF, 5, 5, 1, 5);
        check("dead_rst", rd1_a, 64'd0);
        check("rst_busy", {63'd0, by2_a}, 64'd0);
        tick();
        drive(0, 0, 0, 0, 5, 6, 0, 0);
        tick();
        drive(1, 1, 6, 64'h66, 6, 5, 1, 6); tick();
        drive(1, 0, 0, 0, 6, 5, 0, 0);
        check("post_rst_data", rd1_a, 64'h66);
        check("post_rst_busy", {63'd0, by1_a}, 64'd1);
        tick();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [63:0] wd;
            wd = {$urandom(), $urandom()};
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 1) == 1), rnd_addr(), wd,
                  rnd_addr(), rnd_addr(), ($urandom_range(0, 2) == 0), rnd_addr());
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
